serial_receiver: RTL and testbench
==================================

Name: serial_receiver

Overview:
UART receive front end for the SUMP command path. It samples the host RX line, deframes 8N1 bytes and assembles SUMP commands: 1-byte short commands and 5-byte long commands. Each complete command is presented as opcode plus 32-bit argument with a single-cycle execute strobe to the command decoder. It is the receive-side counterpart of serial_transmitter and shares its FREQ/RATE parameters and bit timing.

Parameters:
FREQ, 100000000, system clock frequency in Hz
RATE, 115200, baud rate in bits/s
BITLENGTH, FREQ/RATE, clocks per bit (derived; must be >= 4)
TIMEOUT_BITS, 40, idle bit-times after which a partial long command is discarded

Ports:
clock  input  1  system clock; all logic on rising edge
extReset_n  input  1  reset; synchronous, active-low
rx  input  1  asynchronous serial input, idle high
op  output  8  opcode of the last complete command
data  output  32  argument of the last complete command (0 for short commands)
execute  output  1  one-cycle strobe: op/data hold a new command
framing_error  output  1  one-cycle strobe: stop bit sampled low

Behaviour:
- Reset (extReset_n=0 at a clock edge) sets:
  - op=0, data=0, execute=0, framing_error=0.
  - Synchroniser flops=1, both FSMs to idle, all counters=0, partial command discarded.
  - Reset mid-byte or mid-command aborts it completely.
- rx passes through a 2-flop synchroniser (2 cycles latency). All decisions use the synchronised value rxs.
- Bit FSM, states RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK:
  - RX_IDLE: rxs==0 -> RX_START, bit counter=0.
  - RX_START: at count BITLENGTH/2-1 (mid start bit), check rxs.
    - rxs==1: glitch, back to RX_IDLE, nothing reported.
    - rxs==0: counter=0 -> RX_DATA.
  - RX_DATA: sample rxs every BITLENGTH clocks (mid-bit), LSB first, shift into an 8-bit register. After the 8th sample -> RX_STOP.
  - RX_STOP: sample at BITLENGTH clocks.
    - rxs==1: byte_valid pulse next cycle, -> RX_IDLE.
    - rxs==0: framing_error pulse, byte dropped, -> RX_BREAK.
  - RX_BREAK: wait for rxs==1, then -> RX_IDLE. This prevents a held-low line (break) from being decoded as 0x00 bytes.
  - Bit counter is 16 bits and saturates-free because BITLENGTH < 65536 is required.
- Command FSM, states CMD_OPCODE, CMD_ARG:
  - CMD_OPCODE, byte_valid, byte[7]==0: op<=byte, data<=0, execute=1 the same cycle op/data update. Stay in CMD_OPCODE.
  - CMD_OPCODE, byte_valid, byte[7]==1: latch opcode internally, byte index=0 -> CMD_ARG. op/data outputs are unchanged.
  - CMD_ARG, byte_valid: argument byte k goes to data bits [8k+7:8k], so the first byte is the LSB.
    - On the 4th byte: op and data update together, execute=1, -> CMD_OPCODE.
- Timing: execute rises 1 cycle after the last stop-bit mid-sample. op/data then hold until the next execute.
- Inter-byte timeout:
  - In CMD_ARG, a counter increments each clock while the bit FSM is in RX_IDLE and clears on any start-bit detection.
  - At TIMEOUT_BITS*BITLENGTH it discards the partial command -> CMD_OPCODE. No execute, no error strobe.
- A framing error during CMD_ARG also discards the partial command -> CMD_OPCODE.
- execute and framing_error are never high in the same cycle. Each is exactly one cycle wide.
- Full-duplex: independent of serial_transmitter activity.

Decomposition:
- Shared package serial_pkg:
  - bit-FSM and command-FSM state encodings;
  - function calc_bitlength(FREQ,RATE);
  - constant LONG_CMD_BIT=7;
  - constant ARG_BYTES=4.
  serial_transmitter migrates to the same BITLENGTH function.
- One sub-module, uart_rx_byte:
  - contains the synchroniser and bit FSM;
  - outputs rx_byte[7:0], byte_valid, framing_error, line_idle.
  The serial_receiver top holds the command FSM and the timeout counter.

Test Plan:
All scenarios use FREQ=1000000, RATE=100000 (BITLENGTH=10) and TIMEOUT_BITS=40.
1. Short command: send 0x01 -> exactly one execute pulse, op=0x01, data=0x00000000, framing_error never asserted.
2. Long command: send 0xC0,0x04,0x03,0x02,0x01 back-to-back -> exactly one execute, after the 5th byte only, with op=0xC0, data=0x01020304. op/data unchanged before it.
3. Glitch: drive rx low for 3 clocks, then high -> no byte_valid, no execute. A following 0x11 -> op=0x11.
4. Framing error and break: send 0x55 with the stop bit low, then hold rx low 100 clocks, release, send 0x02 -> one framing_error pulse, then a single execute with op=0x02 and no spurious 0x00 command.
5. Timeout: send 0x80,0x11, idle 450 clocks, send 0x00 -> no execute for the partial command, then execute with op=0x00, data=0.
6. Reset mid-operation: assert extReset_n=0 during the 4th data bit of the 2nd byte of a long command -> all outputs 0. After release, 0x11 alone -> execute with op=0x11, data=0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the SUMP serial receive/transmit path.
package serial_pkg;

  // Bit-level receive FSM.
  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxBreak
  } rx_state_e;

  // Command assembly FSM.
  typedef enum logic [0:0] {
    CmdOpcode,
    CmdArg
  } cmd_state_e;

  // Opcode bit that marks a 5-byte long command.
  localparam int unsigned LongCmdBit = 7;
  // Argument bytes following a long opcode.
  localparam int unsigned ArgBytes = 4;

  // Clocks per serial bit.
  function automatic int unsigned calc_bitlength(input int unsigned freq,
                                                 input int unsigned rate);
    return freq / rate;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte deframer: rx synchroniser plus bit-level FSM.
module uart_rx_byte
  import serial_pkg::*;
#(
  parameter int unsigned BITLENGTH = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_rx_byte,
  output logic       o_byte_valid,
  output logic       o_framing_error,
  output logic       o_line_idle
);

  localparam logic [15:0] HalfLast = 16'(BITLENGTH / 2 - 1);
  localparam logic [15:0] BitLast  = 16'(BITLENGTH - 1);

  logic      r_sync1, r_sync2;
  rx_state_e r_state, w_state_next;
  logic [15:0] r_cnt, w_cnt_next;
  logic [2:0]  r_bit_idx, w_bit_idx_next;
  logic [7:0]  r_shift, w_shift_next;
  logic        r_valid, w_valid_next;
  logic        r_ferr, w_ferr_next;
  logic        w_rxs;

  assign w_rxs = r_sync2;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Bit FSM state and datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= RxIdle;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_valid   <= w_valid_next;
      r_ferr    <= w_ferr_next;
    end
  end

  // Next-state: mid-bit sampling, LSB first, break lockout after a bad stop bit.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_valid_next   = 1'b0;
    w_ferr_next    = 1'b0;
    case (r_state)
      RxIdle: begin
        if (!w_rxs) begin
          w_state_next = RxStart;
          w_cnt_next   = '0;
        end
      end
      RxStart: begin
        if (r_cnt == HalfLast) begin
          if (w_rxs) begin
            // Start bit did not hold to mid-bit: treat as a glitch.
            w_state_next = RxIdle;
          end else begin
            w_state_next   = RxData;
            w_cnt_next     = '0;
            w_bit_idx_next = '0;
          end
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      RxData: begin
        if (r_cnt == BitLast) begin
          w_cnt_next     = '0;
          w_shift_next   = {w_rxs, r_shift[7:1]};
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_next = RxStop;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      RxStop: begin
        if (r_cnt == BitLast) begin
          w_cnt_next = '0;
          if (w_rxs) begin
            w_valid_next = 1'b1;
            w_state_next = RxIdle;
          end else begin
            w_ferr_next  = 1'b1;
            w_state_next = RxBreak;
          end
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      RxBreak: begin
        // Hold off until the line returns high so a break is not read as 0x00s.
        if (w_rxs) w_state_next = RxIdle;
      end
      default: w_state_next = RxIdle;
    endcase
  end

  assign o_rx_byte       = r_shift;
  assign o_byte_valid    = r_valid;
  assign o_framing_error = r_ferr;
  assign o_line_idle     = (r_state == RxIdle);

endmodule

// File: rtl/serial_receiver.sv
// SUMP command receiver: assembles short (1-byte) and long (5-byte) commands.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int unsigned FREQ         = 100000000,
  parameter int unsigned RATE         = 115200,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic        clock,
  input  logic        extReset_n,
  input  logic        rx,
  output logic [7:0]  op,
  output logic [31:0] data,
  output logic        execute,
  output logic        framing_error
);

  localparam int unsigned BITLENGTH = calc_bitlength(FREQ, RATE);
  localparam logic [31:0] TmoLast   = 32'(TIMEOUT_BITS * BITLENGTH - 1);
  localparam logic [1:0]  LastArg   = 2'(ArgBytes - 1);

  logic [7:0] w_rx_byte;
  logic       w_byte_valid;
  logic       w_ferr;
  logic       w_line_idle;

  uart_rx_byte #(
    .BITLENGTH(BITLENGTH)
  ) u_rx_byte (
    .i_clk          (clock),
    .i_rst_n        (extReset_n),
    .i_rx           (rx),
    .o_rx_byte      (w_rx_byte),
    .o_byte_valid   (w_byte_valid),
    .o_framing_error(w_ferr),
    .o_line_idle    (w_line_idle)
  );

  cmd_state_e  r_state, w_state_next;
  logic [7:0]  r_opcode, w_opcode_next;
  logic [31:0] r_arg, w_arg_next;
  logic [1:0]  r_idx, w_idx_next;
  logic [31:0] r_tmo, w_tmo_next;
  logic [7:0]  r_op, w_op_next;
  logic [31:0] r_data, w_data_next;
  logic        r_execute, w_execute_next;

  // Command FSM, partial-command registers, timeout counter and outputs.
  always_ff @(posedge clock) begin
    if (!extReset_n) begin
      r_state   <= CmdOpcode;
      r_opcode  <= '0;
      r_arg     <= '0;
      r_idx     <= '0;
      r_tmo     <= '0;
      r_op      <= '0;
      r_data    <= '0;
      r_execute <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_opcode  <= w_opcode_next;
      r_arg     <= w_arg_next;
      r_idx     <= w_idx_next;
      r_tmo     <= w_tmo_next;
      r_op      <= w_op_next;
      r_data    <= w_data_next;
      r_execute <= w_execute_next;
    end
  end

  // Next-state: byte arrival beats framing error beats timeout.
  always_comb begin
    w_state_next   = r_state;
    w_opcode_next  = r_opcode;
    w_arg_next     = r_arg;
    w_idx_next     = r_idx;
    w_tmo_next     = '0;
    w_op_next      = r_op;
    w_data_next    = r_data;
    w_execute_next = 1'b0;
    case (r_state)
      CmdOpcode: begin
        if (w_byte_valid) begin
          if (!w_rx_byte[LongCmdBit]) begin
            w_op_next      = w_rx_byte;
            w_data_next    = '0;
            w_execute_next = 1'b1;
          end else begin
            w_opcode_next = w_rx_byte;
            w_arg_next    = '0;
            w_idx_next    = '0;
            w_state_next  = CmdArg;
          end
        end
      end
      CmdArg: begin
        if (w_byte_valid) begin
          // Shift in from the top so the first argument byte ends up in bits [7:0].
          w_arg_next = {w_rx_byte, r_arg[31:8]};
          if (r_idx == LastArg) begin
            w_op_next      = r_opcode;
            w_data_next    = {w_rx_byte, r_arg[31:8]};
            w_execute_next = 1'b1;
            w_state_next   = CmdOpcode;
          end else begin
            w_idx_next = r_idx + 2'd1;
          end
        end else if (w_ferr) begin
          w_state_next = CmdOpcode;
        end else if (w_line_idle) begin
          if (r_tmo == TmoLast) begin
            w_state_next = CmdOpcode;
          end else begin
            w_tmo_next = r_tmo + 32'd1;
          end
        end
      end
      default: w_state_next = CmdOpcode;
    endcase
  end

  assign op            = r_op;
  assign data          = r_data;
  assign execute       = r_execute;
  assign framing_error = w_ferr;

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver (BITLENGTH = 10, TIMEOUT_BITS = 40).
module tb_serial_receiver;

  localparam int BL = 10;

  logic        clock = 1'b0;
  logic        extReset_n = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  op;
  logic [31:0] data;
  logic        execute;
  logic        framing_error;

  int errors = 0;
  int checks = 0;
  int ferr_seen = 0;
  int ferr_exp = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  exp_op = 8'h00;
  logic [31:0] exp_data = 32'h0;

  serial_receiver #(
    .FREQ        (1000000),
    .RATE        (100000),
    .TIMEOUT_BITS(40)
  ) dut (
    .clock        (clock),
    .extReset_n   (extReset_n),
    .rx           (rx),
    .op           (op),
    .data         (data),
    .execute      (execute),
    .framing_error(framing_error)
  );

  always #5 clock = ~clock;

  // Monitor: pops an expectation on every execute, otherwise checks op/data hold.
  initial begin
    logic [39:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (!extReset_n) begin
        exp_q.delete();
        exp_op = 8'h00;
        exp_data = 32'h0;
      end
      if (execute || framing_error) begin
        checks++;
        if (execute && framing_error) begin
          errors++;
          $display("FAIL strobe_overlap: execute=%b framing_error=%b, required not both", execute,
                   framing_error);
        end
      end
      if (framing_error) ferr_seen++;
      if (execute) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_execute: op=%h data=%h, required no execute", op, data);
        end else begin
          e = exp_q.pop_front();
          exp_op = e[39:32];
          exp_data = e[31:0];
          if (op !== exp_op || data !== exp_data) begin
            errors++;
            $display("FAIL command: op=%h data=%h, required op=%h data=%h", op, data, exp_op,
                     exp_data);
          end
        end
      end else begin
        checks++;
        if (op !== exp_op || data !== exp_data) begin
          errors++;
          $display("FAIL hold: op=%h data=%h, required op=%h data=%h", op, data, exp_op,
                   exp_data);
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_clks(BL);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BL);
    end
    rx = stop;
    wait_clks(BL);
    rx = 1'b1;
  endtask

  task automatic expect_cmd(input logic [7:0] o, input logic [31:0] d);
    exp_q.push_back({o, d});
  endtask

  // Bounded wait for the scoreboard to empty.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: pending=%0d, required 0", name, exp_q.size());
      exp_q.delete();
    end
    wait_clks(30);
  endtask

  task automatic check_outputs(input string name);
    checks++;
    if (op !== 8'h00 || data !== 32'h0 || execute !== 1'b0 || framing_error !== 1'b0) begin
      errors++;
      $display("FAIL %s: op=%h data=%h exec=%b ferr=%b, required all zero", name, op, data,
               execute, framing_error);
    end
  endtask

  initial begin
    wait_clks(5);
    check_outputs("reset_state");
    extReset_n = 1'b1;
    wait_clks(20);

    // 1. Short command.
    expect_cmd(8'h01, 32'h0);
    send_frame(8'h01, 1'b1);
    drain("short");

    // 2. Long command, argument LSB first.
    expect_cmd(8'hC0, 32'h01020304);
    send_frame(8'hC0, 1'b1);
    send_frame(8'h04, 1'b1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h01, 1'b1);
    drain("long");

    // 3. Start-bit glitch, then a real byte.
    rx = 1'b0;
    wait_clks(3);
    rx = 1'b1;
    wait_clks(40);
    expect_cmd(8'h11, 32'h0);
    send_frame(8'h11, 1'b1);
    drain("glitch");

    // 4. Framing error followed by a held break.
    ferr_exp++;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    wait_clks(100);
    rx = 1'b1;
    wait_clks(30);
    expect_cmd(8'h02, 32'h0);
    send_frame(8'h02, 1'b1);
    drain("break");

    // 5. Inter-byte timeout discards a partial long command.
    send_frame(8'h80, 1'b1);
    send_frame(8'h11, 1'b1);
    wait_clks(450);
    expect_cmd(8'h00, 32'h0);
    send_frame(8'h00, 1'b1);
    drain("timeout");

    // 6. Reset during data bit 3 of the second byte of a long command.
    send_frame(8'h80, 1'b1);
    rx = 1'b0;
    wait_clks(BL);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      wait_clks(BL);
    end
    rx = 1'b0;
    wait_clks(5);
    extReset_n = 1'b0;
    rx = 1'b1;
    wait_clks(3);
    check_outputs("reset_mid_cmd");
    extReset_n = 1'b1;
    wait_clks(20);
    expect_cmd(8'h11, 32'h0);
    send_frame(8'h11, 1'b1);
    drain("after_reset");

    checks++;
    if (ferr_seen != ferr_exp) begin
      errors++;
      $display("FAIL framing_count: seen=%0d, required %0d", ferr_seen, ferr_exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
